// File: rtl/ts_arb_pkg.sv
// Shared encodings and sizes for the TS packet arbiter.
package ts_arb_pkg;

  localparam int ST_WIDTH      = 3;
  localparam int TS_WORD_WIDTH = 32;
  localparam int TS_PKT_WORDS  = 47;

  typedef enum logic [ST_WIDTH-1:0] {
    ST_IDLE  = 3'b001,
    ST_GRANT = 3'b010,
    ST_XFER  = 3'b100
  } arb_state_e;

endpackage

// File: rtl/ts_pkt_arbiter_rr_sel.sv
// Round-robin selector: first requesting port after rr_ptr, modulo PORT_NUM.
module rr_sel #(
  parameter int PORT_BIT_WIDTH = 2,
  parameter int PORT_NUM       = 2**PORT_BIT_WIDTH
) (
  input  logic [PORT_NUM-1:0]       req,
  input  logic [PORT_BIT_WIDTH-1:0] rr_ptr,
  output logic [PORT_BIT_WIDTH-1:0] sel,
  output logic                      any_req
);

  logic [PORT_BIT_WIDTH-1:0] start;
  logic [PORT_NUM-1:0]       rot;
  logic [PORT_BIT_WIDTH-1:0] enc;

  // Index arithmetic wraps naturally because PORT_NUM is a power of two.
  assign start = rr_ptr + 1'b1;
  assign rot   = PORT_NUM'({req, req} >> start);

  always_comb begin
    enc = '0;
    for (int i = PORT_NUM - 1; i >= 0; i--) begin
      if (rot[i]) enc = PORT_BIT_WIDTH'(i);
    end
  end

  assign sel     = start + enc;
  assign any_req = |req;

endmodule

// File: rtl/ts_pkt_arbiter.sv
// Packet-level round-robin arbiter merging PORT_NUM TS word streams into one.
module ts_pkt_arbiter
  import ts_arb_pkg::*;
#(
  parameter int PORT_BIT_WIDTH = 2,
  parameter int PORT_NUM       = 2**PORT_BIT_WIDTH,
  parameter int MAX_PKT_WORDS  = TS_PKT_WORDS,
  parameter int WCNT_WIDTH     = 6,
  parameter int SOP_TIMEOUT    = 15,
  parameter int TCNT_WIDTH     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PORT_NUM-1:0]               req,
  input  logic [PORT_NUM*TS_WORD_WIDTH-1:0] ts_i_data,
  input  logic [PORT_NUM-1:0]               ts_i_val,
  input  logic [PORT_NUM-1:0]               ts_i_sop,
  input  logic [PORT_NUM-1:0]               ts_i_eop,
  output logic [PORT_NUM-1:0]               grant,
  output logic [TS_WORD_WIDTH-1:0]          ts_o_data,
  output logic                              ts_o_val,
  output logic                              ts_o_sop,
  output logic                              ts_o_eop,
  output logic [PORT_BIT_WIDTH-1:0]         ts_o_port,
  output logic                              err_pkt,
  output logic                              err_timeout
);

  arb_state_e                state, state_nxt;
  logic [PORT_NUM-1:0]       grant_nxt;
  logic [PORT_BIT_WIDTH-1:0] gnt_idx, gnt_idx_nxt;
  logic [PORT_BIT_WIDTH-1:0] rr_ptr, rr_ptr_nxt;
  logic [TCNT_WIDTH-1:0]     tcnt, tcnt_nxt;
  logic [WCNT_WIDTH-1:0]     wcnt, wcnt_nxt;
  logic [PORT_BIT_WIDTH-1:0] sel;
  logic                      any_req;
  logic                      fwd, o_sop, o_eop, err_pkt_nxt, err_to_nxt, release_pkt;

  logic                      cur_val, cur_sop, cur_eop;
  logic [TS_WORD_WIDTH-1:0]  cur_data;

  rr_sel #(
    .PORT_BIT_WIDTH(PORT_BIT_WIDTH),
    .PORT_NUM      (PORT_NUM)
  ) u_rr_sel (
    .req    (req),
    .rr_ptr (rr_ptr),
    .sel    (sel),
    .any_req(any_req)
  );

  // Only the granted port is ever looked at.
  assign cur_val  = ts_i_val[gnt_idx];
  assign cur_sop  = ts_i_sop[gnt_idx];
  assign cur_eop  = ts_i_eop[gnt_idx];
  assign cur_data = ts_i_data[gnt_idx*TS_WORD_WIDTH +: TS_WORD_WIDTH];

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    gnt_idx_nxt = gnt_idx;
    rr_ptr_nxt  = rr_ptr;
    tcnt_nxt    = tcnt;
    wcnt_nxt    = wcnt;
    fwd         = 1'b0;
    o_sop       = 1'b0;
    o_eop       = 1'b0;
    err_pkt_nxt = 1'b0;
    err_to_nxt  = 1'b0;
    release_pkt = 1'b0;

    case (state)
      ST_IDLE: begin
        grant_nxt = '0;
        if (any_req) begin
          grant_nxt   = PORT_NUM'(1) << sel;
          gnt_idx_nxt = sel;
          tcnt_nxt    = '0;
          state_nxt   = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (cur_val && cur_sop) begin
          fwd   = 1'b1;
          o_sop = 1'b1;
          o_eop = cur_eop;
          if (cur_eop) begin
            release_pkt = 1'b1;
          end else begin
            wcnt_nxt  = WCNT_WIDTH'(1);
            state_nxt = ST_XFER;
          end
        end else if (tcnt == TCNT_WIDTH'(SOP_TIMEOUT - 1)) begin
          err_to_nxt  = 1'b1;
          release_pkt = 1'b1;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      ST_XFER: begin
        if (cur_val) begin
          fwd         = 1'b1;
          wcnt_nxt    = wcnt + 1'b1;
          err_pkt_nxt = cur_sop;
          if (cur_eop) begin
            o_eop       = 1'b1;
            release_pkt = 1'b1;
          end else if (wcnt == WCNT_WIDTH'(MAX_PKT_WORDS - 1)) begin
            // Overlength packet is cut here with a synthetic eop.
            o_eop       = 1'b1;
            err_pkt_nxt = 1'b1;
            release_pkt = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (release_pkt) begin
      state_nxt  = ST_IDLE;
      grant_nxt  = '0;
      rr_ptr_nxt = gnt_idx;
      wcnt_nxt   = '0;
    end
  end

  // NOTE: registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant   <= '0;
      gnt_idx <= '0;
      rr_ptr  <= PORT_BIT_WIDTH'(PORT_NUM - 1);
      tcnt    <= '0;
      wcnt    <= '0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      gnt_idx <= gnt_idx_nxt;
      rr_ptr  <= rr_ptr_nxt;
      tcnt    <= tcnt_nxt;
      wcnt    <= wcnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_o_data   <= '0;
      ts_o_val    <= 1'b0;
      ts_o_sop    <= 1'b0;
      ts_o_eop    <= 1'b0;
      ts_o_port   <= '0;
      err_pkt     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      ts_o_data   <= fwd ? cur_data : '0;
      ts_o_val    <= fwd;
      ts_o_sop    <= o_sop;
      ts_o_eop    <= o_eop;
      ts_o_port   <= fwd ? gnt_idx : '0;
      err_pkt     <= err_pkt_nxt;
      err_timeout <= err_to_nxt;
    end
  end

endmodule

// File: tb/tb_ts_pkt_arbiter.sv
// Directed self-checking bench for ts_pkt_arbiter.
module tb_ts_pkt_arbiter;

  localparam int PN = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [PN-1:0]   req = '0;
  logic [PN*32-1:0] ts_i_data = '0;
  logic [PN-1:0]   ts_i_val = '0;
  logic [PN-1:0]   ts_i_sop = '0;
  logic [PN-1:0]   ts_i_eop = '0;
  logic [PN-1:0]   grant;
  logic [31:0]     ts_o_data;
  logic            ts_o_val, ts_o_sop, ts_o_eop;
  logic [1:0]      ts_o_port;
  logic            err_pkt, err_timeout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ts_pkt_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .ts_i_data  (ts_i_data),
    .ts_i_val   (ts_i_val),
    .ts_i_sop   (ts_i_sop),
    .ts_i_eop   (ts_i_eop),
    .grant      (grant),
    .ts_o_data  (ts_o_data),
    .ts_o_val   (ts_o_val),
    .ts_o_sop   (ts_o_sop),
    .ts_o_eop   (ts_o_eop),
    .ts_o_port  (ts_o_port),
    .err_pkt    (err_pkt),
    .err_timeout(err_timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] word_data(input int p, input int k);
    return {8'(p), 8'h5A, 16'(k)};
  endfunction

  function automatic logic [PN-1:0] onehot(input int p);
    return PN'(1) << p;
  endfunction

  function automatic logic [38:0] out_vec();
    return {ts_o_val, ts_o_sop, ts_o_eop, ts_o_port, ts_o_data, err_pkt, err_timeout};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input bit v, input bit s, input bit e, input logic [31:0] d);
    ts_i_val[p] = v;
    ts_i_sop[p] = s;
    ts_i_eop[p] = e;
    ts_i_data[p*32 +: 32] = d;
  endtask

  task automatic clear_lanes();
    ts_i_val  = '0;
    ts_i_sop  = '0;
    ts_i_eop  = '0;
    ts_i_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    clear_lanes();
    tick();
    tick();
    check("reset_state", {grant, out_vec()}, '0);
    rst = 1'b0;
  endtask

  task automatic wait_grant(input string tag, input logic [PN-1:0] exp_grant);
    tick();
    check({tag, "_grant"}, grant, exp_grant);
    check({tag, "_gap"}, ts_o_val, 1'b0);
  endtask

  // Drives n words on port p (already granted) and checks each word one cycle later.
  task automatic send_pkt(input int p, input int n, input int sop_at, input bit with_eop,
                          input int drop_at);
    bit          active = 1'b1;
    bit          e_eop, e_err;
    logic [38:0] exp;
    for (int k = 1; k <= n; k++) begin
      if (k == drop_at) req[p] = 1'b0;
      drive(p, 1'b1, (k == 1) || (k == sop_at), with_eop && (k == n), word_data(p, k));
      tick();
      if (active) begin
        e_eop = (with_eop && k == n) || (k == 47);
        e_err = (k == sop_at && k != 1) || (k == 47 && !(with_eop && k == n));
        exp   = {1'b1, k == 1, e_eop, 2'(p), word_data(p, k), e_err, 1'b0};
        if (e_eop) active = 1'b0;
      end else begin
        exp = '0;
      end
      check($sformatf("p%0d_w%0d", p, k), out_vec(), exp);
      check($sformatf("p%0d_w%0d_grant", p, k), grant, active ? onehot(p) : '0);
    end
    drive(p, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    // Single port, full-length packet.
    do_reset();
    req = 4'b0001;
    wait_grant("t1", 4'b0001);
    send_pkt(0, 47, 0, 1'b1, 0);
    req = '0;

    // Fairness with all ports requesting after reset: 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant($sformatf("t2_%0d", i), onehot(i % 4));
      send_pkt(i % 4, 47, 0, 1'b1, 0);
    end
    req = '0;

    // Sop timeout on port 2, port 3 served next.
    req = 4'b1100;
    wait_grant("t3", 4'b0100);
    for (int k = 1; k <= 14; k++) begin
      tick();
      check($sformatf("t3_wait%0d", k), {grant, err_timeout, ts_o_val}, {4'b0100, 2'b00});
    end
    tick();
    check("t3_timeout", {grant, err_timeout, ts_o_val}, {4'b0000, 2'b10});
    wait_grant("t3_next", 4'b1000);
    check("t3_err_clear", err_timeout, 1'b0);
    send_pkt(3, 2, 0, 1'b1, 0);
    req = '0;

    // Overlength packet from port 1, req dropped mid-packet, then a clean packet.
    req = 4'b0010;
    wait_grant("t4", 4'b0010);
    send_pkt(1, 60, 0, 1'b0, 40);
    req = 4'b0010;
    wait_grant("t4_clean", 4'b0010);
    send_pkt(1, 3, 0, 1'b1, 0);
    req = '0;

    // Mid-packet sop, then a single-word packet.
    req = 4'b0001;
    wait_grant("t5", 4'b0001);
    send_pkt(0, 20, 10, 1'b1, 0);
    wait_grant("t5_single", 4'b0001);
    send_pkt(0, 1, 0, 1'b1, 0);
    req = '0;
    tick();
    check("t5_idle", {grant, out_vec()}, '0);

    // Reset at word 20 of a port 1 packet; port 0 wins afterwards.
    req = 4'b0011;
    wait_grant("t6", 4'b0010);
    send_pkt(1, 20, 0, 1'b0, 0);
    rst = 1'b1;
    drive(1, 1'b1, 1'b0, 1'b0, word_data(1, 21));
    tick();
    check("t6_reset_outputs", {grant, out_vec()}, '0);
    clear_lanes();
    rst = 1'b0;
    wait_grant("t6_after", 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
